// File: rtl/clk_div_pkg.sv
// Shared types, constants and ratio helpers for the programmable clock divider.
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } chan_state_e;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam int MIN_RATIO = 2;

  // A ratio of 1 cannot produce a high and a low phase, so it runs as 2.
  function automatic logic [31:0] eff_ratio(input logic [31:0] r);
    return (r == 32'd1) ? 32'(MIN_RATIO) : r;
  endfunction

  // High-phase length ceil(R/2); one extra bit keeps R = 2^W-1 from wrapping.
  function automatic logic [32:0] high_phase(input logic [31:0] r);
    logic [32:0] e;
    e = {1'b0, eff_ratio(r)};
    return (e + 33'd1) >> 1;
  endfunction

endpackage

// File: rtl/clk_divider_prog_if.sv
// Control and output bundle of the multi-channel programmable clock divider.
interface clk_divider_prog_if #(
  parameter int CH = 2,
  parameter int W  = 8
);
  logic [CH-1:0]   en;
  logic [CH-1:0]   load;
  logic [CH*W-1:0] div_ratio;
  logic [CH-1:0]   clk_out;
  logic [CH-1:0]   tick;
  logic [CH-1:0]   busy;

  modport master (output en, load, div_ratio, input clk_out, tick, busy);
  modport slave  (input en, load, div_ratio, output clk_out, tick, busy);
endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: FSM, period counter, active/pending ratio and registered outputs.
//
// state | meaning
// IDLE  | output low, counter parked at 0, ratio loads apply immediately
// RUN   | counting 0..R-1, output high while cnt < ceil(R/2)
// DRAIN | en dropped, finishing the current period before going idle
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int W             = 8,
  parameter int DEFAULT_RATIO = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] ratio_in,
  output logic         clk_out,
  output logic         tick,
  output logic         busy
);

  logic [1:0]   state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] r_q, r_d;
  logic [W-1:0] p_q, p_d;
  logic         pv_q, pv_d;
  logic         clk_out_d, tick_d, busy_d;
  logic [W-1:0] r_eff;
  logic [W:0]   h_cur;
  logic         boundary;

  always_comb begin
    r_eff     = W'(eff_ratio(32'(r_q)));
    h_cur     = (W+1)'(high_phase(32'(r_q)));
    boundary  = (state_q != ST_IDLE) && (cnt_q == r_eff - 1'b1);
    state_d   = state_q;
    cnt_d     = cnt_q;
    r_d       = r_q;
    p_d       = p_q;
    pv_d      = pv_q;
    clk_out_d = 1'b0;
    tick_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (load) r_d = ratio_in;
        if (en && (r_d != '0)) begin
          state_d   = ST_RUN;
          clk_out_d = 1'b1;
          tick_d    = 1'b1;
        end
      end
      ST_RUN, ST_DRAIN: begin
        if (boundary) begin
          // A load coinciding with the boundary overrides anything pending.
          r_d   = load ? ratio_in : (pv_q ? p_q : r_q);
          pv_d  = 1'b0;
          cnt_d = '0;
          if (!en || (r_d == '0)) begin
            state_d = ST_IDLE;
          end else begin
            state_d   = ST_RUN;
            clk_out_d = 1'b1;
            tick_d    = 1'b1;
          end
        end else begin
          if (load) begin
            p_d  = ratio_in;
            pv_d = 1'b1;
          end
          cnt_d     = cnt_q + 1'b1;
          clk_out_d = ({1'b0, cnt_d} < h_cur);
          state_d   = en ? ST_RUN : ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      r_q     <= W'(DEFAULT_RATIO);
      p_q     <= '0;
      pv_q    <= 1'b0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      p_q     <= p_d;
      pv_q    <= pv_d;
      clk_out <= clk_out_d;
      tick    <= tick_d;
      busy    <= busy_d;
    end
  end

endmodule

// File: rtl/clk_divider_prog.sv
// Multi-channel runtime-programmable integer clock divider; channels are fully independent.
module clk_divider_prog #(
  parameter int CH            = 2,
  parameter int W             = 8,
  parameter int DEFAULT_RATIO = 4
) (
  input logic               clk,
  input logic               rst_n,
  clk_divider_prog_if.slave bus
);

  for (genvar gi = 0; gi < CH; gi++) begin : g_chan
    clk_div_chan #(
      .W             (W),
      .DEFAULT_RATIO (DEFAULT_RATIO)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (bus.en[gi]),
      .load     (bus.load[gi]),
      .ratio_in (bus.div_ratio[gi*W +: W]),
      .clk_out  (bus.clk_out[gi]),
      .tick     (bus.tick[gi]),
      .busy     (bus.busy[gi])
    );
  end

endmodule

// File: tb/tb_clk_divider_prog.sv
// Directed self-checking bench for clk_divider_prog with two 8-bit channels.
module tb_clk_divider_prog;
  localparam int CH = 2;
  localparam int W  = 8;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  clk_divider_prog_if #(.CH(CH), .W(W)) bus ();

  clk_divider_prog #(.CH(CH), .W(W), .DEFAULT_RATIO(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ratio(input int ch, input logic [W-1:0] val);
    bus.div_ratio[ch*W +: W] = val;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.en        = '0;
    bus.load      = '0;
    bus.div_ratio = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.en        = '0;
    bus.load      = '0;
    bus.div_ratio = '0;
    #3;
    checks++;
    if ({bus.clk_out, bus.tick, bus.busy} !== 6'b0) begin
      errors++;
      $display("FAIL reset_async outputs=%b expected 000000", {bus.clk_out, bus.tick, bus.busy});
    end
    bus.en = 2'b11;
    repeat (3) step();
    checks++;
    if ({bus.clk_out, bus.tick, bus.busy} !== 6'b0) begin
      errors++;
      $display("FAIL reset_held_en outputs=%b expected 000000", {bus.clk_out, bus.tick, bus.busy});
    end
    bus.en = '0;
    rst_n  = 1'b1;
    repeat (3) step();
    checks++;
    if ({bus.clk_out, bus.tick, bus.busy} !== 6'b0) begin
      errors++;
      $display("FAIL reset_idle outputs=%b expected 000000", {bus.clk_out, bus.tick, bus.busy});
    end
  endtask

  task automatic test_default();
    logic c, t;
    do_reset();
    bus.en = 2'b11;
    for (int i = 0; i < 12; i++) begin
      step();
      c = (i % 4) < 2;
      t = (i % 4) == 0;
      checks++;
      if (bus.clk_out !== {c, c} || bus.tick !== {t, t} || bus.busy !== 2'b11) begin
        errors++;
        $display("FAIL default_r4 i=%0d clk_out=%b tick=%b busy=%b expected clk=%b tick=%b busy=11",
                 i, bus.clk_out, bus.tick, bus.busy, c, t);
      end
    end
    step();
    checks++;
    if (bus.clk_out !== 2'b11) begin
      errors++;
      $display("FAIL default_high_before_rst clk_out=%b expected 11", bus.clk_out);
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.clk_out, bus.tick, bus.busy} !== 6'b0) begin
      errors++;
      $display("FAIL midphase_rst outputs=%b expected 000000", {bus.clk_out, bus.tick, bus.busy});
    end
    bus.en = '0;
  endtask

  task automatic test_odd();
    logic c, t;
    do_reset();
    set_ratio(0, 8'd5);
    bus.load = 2'b01;
    step();
    bus.load = '0;
    bus.en   = 2'b01;
    for (int i = 0; i < 10; i++) begin
      step();
      c = (i % 5) < 3;
      t = (i % 5) == 0;
      checks++;
      if (bus.clk_out !== {1'b0, c} || bus.tick !== {1'b0, t} || bus.busy !== 2'b01) begin
        errors++;
        $display("FAIL odd_r5 i=%0d clk_out=%b tick=%b busy=%b expected clk=0%b tick=0%b busy=01",
                 i, bus.clk_out, bus.tick, bus.busy, c, t);
      end
    end
    bus.en = '0;
    step();
    checks++;
    if (bus.busy[0] !== 1'b0 || bus.clk_out[0] !== 1'b0) begin
      errors++;
      $display("FAIL odd_r5_stop busy=%b clk_out=%b expected 0 0", bus.busy[0], bus.clk_out[0]);
    end
    set_ratio(0, 8'd255);
    bus.load = 2'b01;
    step();
    bus.load = '0;
    bus.en   = 2'b01;
    for (int i = 0; i < 256; i++) begin
      step();
      c = (i % 255) < 128;
      t = (i % 255) == 0;
      checks++;
      if (bus.clk_out[0] !== c || bus.tick[0] !== t) begin
        errors++;
        $display("FAIL odd_r255 i=%0d clk_out=%b tick=%b expected %b %b",
                 i, bus.clk_out[0], bus.tick[0], c, t);
      end
    end
    bus.en = '0;
    repeat (254) step();
    checks++;
    if (bus.busy[0] !== 1'b1 || bus.clk_out[0] !== 1'b0) begin
      errors++;
      $display("FAIL r255_drain_last busy=%b clk_out=%b expected 1 0", bus.busy[0], bus.clk_out[0]);
    end
    step();
    checks++;
    if (bus.busy[0] !== 1'b0 || bus.clk_out[0] !== 1'b0) begin
      errors++;
      $display("FAIL r255_drain_idle busy=%b clk_out=%b expected 0 0", bus.busy[0], bus.clk_out[0]);
    end
  endtask

  task automatic test_runtime();
    logic c, t;
    do_reset();
    bus.en = 2'b01;
    for (int i = 0; i < 36; i++) begin
      step();
      if (i < 4) begin
        c = i < 2;
        t = i == 0;
      end else if (i < 22) begin
        c = ((i - 4) % 6) < 3;
        t = ((i - 4) % 6) == 0;
      end else begin
        c = ((i - 22) % 7) < 4;
        t = ((i - 22) % 7) == 0;
      end
      checks++;
      if (bus.clk_out[0] !== c || bus.tick[0] !== t || bus.busy[0] !== 1'b1) begin
        errors++;
        $display("FAIL runtime_load i=%0d clk_out=%b tick=%b busy=%b expected %b %b 1",
                 i, bus.clk_out[0], bus.tick[0], bus.busy[0], c, t);
      end
      bus.load = '0;
      if (i == 1) begin
        set_ratio(0, 8'd6);
        bus.load = 2'b01;
      end else if (i == 16) begin
        set_ratio(0, 8'd3);
        bus.load = 2'b01;
      end else if (i == 17) begin
        set_ratio(0, 8'd7);
        bus.load = 2'b01;
      end
    end
    bus.en = '0;
  endtask

  task automatic test_boundary();
    logic c, t, b;
    do_reset();
    bus.en = 2'b01;
    for (int i = 0; i < 26; i++) begin
      step();
      if (i < 4) begin
        c = i < 2;
        t = i == 0;
        b = 1'b1;
      end else if (i < 20) begin
        c = ((i - 4) % 8) < 4;
        t = ((i - 4) % 8) == 0;
        b = 1'b1;
      end else begin
        c = 1'b0;
        t = 1'b0;
        b = 1'b0;
      end
      checks++;
      if (bus.clk_out[0] !== c || bus.tick[0] !== t || bus.busy[0] !== b) begin
        errors++;
        $display("FAIL boundary_load i=%0d clk_out=%b tick=%b busy=%b expected %b %b %b",
                 i, bus.clk_out[0], bus.tick[0], bus.busy[0], c, t, b);
      end
      bus.load = '0;
      if (i == 3) begin
        set_ratio(0, 8'd8);
        bus.load = 2'b01;
      end else if (i == 13) begin
        set_ratio(0, 8'd0);
        bus.load = 2'b01;
      end
    end
    bus.en = '0;
  endtask

  task automatic test_stop_restart();
    logic c, t, b;
    do_reset();
    set_ratio(0, 8'd6);
    bus.load = 2'b01;
    step();
    bus.load = '0;
    bus.en   = 2'b01;
    for (int i = 0; i < 9; i++) begin
      step();
      c = (i < 6) && (i < 3);
      t = i == 0;
      b = i < 6;
      checks++;
      if (bus.clk_out[0] !== c || bus.tick[0] !== t || bus.busy[0] !== b) begin
        errors++;
        $display("FAIL stop_drain i=%0d clk_out=%b tick=%b busy=%b expected %b %b %b",
                 i, bus.clk_out[0], bus.tick[0], bus.busy[0], c, t, b);
      end
      if (i == 1) bus.en = '0;
    end
    bus.en = 2'b01;
    for (int j = 0; j < 18; j++) begin
      step();
      c = (j % 6) < 3;
      t = (j % 6) == 0;
      checks++;
      if (bus.clk_out[0] !== c || bus.tick[0] !== t || bus.busy[0] !== 1'b1) begin
        errors++;
        $display("FAIL restart_cont j=%0d clk_out=%b tick=%b busy=%b expected %b %b 1",
                 j, bus.clk_out[0], bus.tick[0], bus.busy[0], c, t);
      end
      if (j == 2) bus.en = '0;
      if (j == 3) bus.en = 2'b01;
    end
    bus.en = '0;
  endtask

  task automatic test_edges();
    logic c0, t0, c1, t1;
    do_reset();
    set_ratio(0, 8'd1);
    set_ratio(1, 8'd0);
    bus.load = 2'b11;
    step();
    bus.load = '0;
    bus.en   = 2'b11;
    for (int i = 0; i < 8; i++) begin
      step();
      c0 = (i % 2) == 0;
      checks++;
      if (bus.clk_out !== {1'b0, c0} || bus.tick !== {1'b0, c0} || bus.busy !== 2'b01) begin
        errors++;
        $display("FAIL ratio1_ratio0 i=%0d clk_out=%b tick=%b busy=%b expected clk=0%b tick=0%b busy=01",
                 i, bus.clk_out, bus.tick, bus.busy, c0, c0);
      end
    end
    do_reset();
    set_ratio(0, 8'd3);
    set_ratio(1, 8'd8);
    bus.load = 2'b11;
    step();
    bus.load = '0;
    bus.en   = 2'b11;
    for (int i = 0; i < 24; i++) begin
      step();
      c0 = (i % 3) < 2;
      t0 = (i % 3) == 0;
      c1 = (i % 8) < 4;
      t1 = (i % 8) == 0;
      checks++;
      if (bus.clk_out !== {c1, c0} || bus.tick !== {t1, t0} || bus.busy !== 2'b11) begin
        errors++;
        $display("FAIL indep_r3_r8 i=%0d clk_out=%b tick=%b busy=%b expected clk=%b%b tick=%b%b busy=11",
                 i, bus.clk_out, bus.tick, bus.busy, c1, c0, t1, t0);
      end
    end
    bus.en = '0;
  endtask

  initial begin
    test_reset();
    test_default();
    test_odd();
    test_runtime();
    test_boundary();
    test_stop_restart();
    test_edges();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_divider_prog.md
# clk_divider_prog

Multi-channel, runtime-programmable integer clock divider, successor to the fixed-ratio divider. Each channel divides `clk` by its own ratio, loaded at run time and applied glitch-free at the next period boundary. Each channel also has a start/stop enable and a one-cycle rising-edge strobe. Outputs are registered divided clocks/enables used by downstream timing and peripheral logic in the same `clk` domain.

## Interface
Parameters:
- `CH`, 2, number of independent channels
- `W`, 8, ratio width in bits; maximum ratio 2^W-1
- `DEFAULT_RATIO`, 4, active ratio of every channel after reset; must be ≥2

Ports:
- `clk`  in  1  system clock; all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `en`  in  CH  per-channel run enable, level
- `load`  in  CH  per-channel one-cycle strobe; captures that channel's ratio slice
- `div_ratio`  in  CH*W  channel i ratio in bits [i*W +: W]
- `clk_out`  out  CH  divided output, registered
- `tick`  out  CH  one-cycle pulse, high in the cycle `clk_out` rises
- `busy`  out  CH  high while the channel is in RUN or DRAIN

## Operation
- Per-channel state: active ratio R, pending ratio P with valid flag PV, counter `cnt` (W bits), FSM.
- Effective ratio: R=0 means channel off and it never enters RUN. R=1 is treated as 2. Otherwise R is used as given.
- Duty: high phase H=ceil(R/2), low phase R-H. Even R gives exactly 50%. Odd R gives one extra high cycle.
- FSM states:
  - IDLE: `clk_out`=0, `cnt`=0. Moves to RUN when `en`=1 and R≠0.
  - RUN: counts 0..R-1 and wraps. `clk_out`=1 while cnt<H. Moves to DRAIN when `en`=0.
  - DRAIN: finishes the current period. Goes back to RUN if `en` returns to 1 before the period boundary. Otherwise goes to IDLE at the boundary.
- Period boundary: the cycle with cnt=R-1 in RUN or DRAIN.
- Ratio loading:
  - `load` in IDLE: R ← slice on the next edge. No pending stage.
  - `load` in RUN/DRAIN: P ← slice, PV ← 1. At the next boundary R ← P and PV ← 0.
  - `load` in the same cycle as a boundary: the new slice goes straight to R (bypasses P).
  - Multiple loads before a boundary: the last one wins.
  - Loading 0 while running stops the channel at that boundary (next state IDLE). No runt pulse.
- Channels are fully independent. No cross-channel phase alignment.
- Reset (async assert, sync deassert inside the block is not required): FSM=IDLE, cnt=0, R=DEFAULT_RATIO, PV=0, `clk_out`=0, `tick`=0, `busy`=0.

## Timing
- `en` sampled high in IDLE on edge t: `clk_out`, `tick` and `busy` are 1 from edge t+1.
- Waveform from that start:
  - `clk_out` high for cycles t+1..t+H and low for t+H+1..t+R.
  - Next rise at t+R+1, so the period is exactly R cycles.
- `tick` is high only in the first high cycle of each period.
- `en` dropped mid-period: the remainder of the period completes unchanged. `busy` falls together with the last low cycle's successor, i.e. `busy`=0 from the edge after the boundary.
- A new ratio takes effect on the first rise after the boundary. The period in which `load` occurred is unaffected.
- `rst_n` asserted mid-period: all outputs go to 0 immediately, without waiting for `clk`.
- Counter compare uses W-bit unsigned arithmetic. H is computed as (R+1)>>1 in W+1 bits to avoid overflow at R=2^W-1.

## Structure
- Package `clk_div_pkg`:
  - FSM state enum {IDLE, RUN, DRAIN}
  - constant MIN_RATIO=2
  - function computing effective ratio and H
- Sub-module `clk_div_chan`: one channel containing the FSM, counter, R/P/PV registers and outputs. The top instantiates CH copies with a generate loop and slices `div_ratio`.

## Test plan
- Reset then `en`=1 with CH=2 at default R=4:
  - `clk_out` pattern 1100 repeating, starting one cycle after `en`.
  - `tick` every 4 cycles.
  - `rst_n` low mid-high-phase forces outputs to 0 at once.
- Odd ratio: load 5 in IDLE, then enable. Pattern is 11100 repeating (3 high, 2 low) and `tick` fires every 5 cycles. Load 255 and confirm H=128 and period=255.
- Runtime change: running at R=4, load 6 mid-period. The current period stays 4 cycles, then the pattern becomes 111000. Load 3 then 7 before the boundary and only 7 takes effect.
- Boundary collision: assert `load`=8 exactly at cnt=R-1. The next period is 8 cycles. `load`=0 while running ends the current period cleanly, then `busy`=0 and the output stays low.
- Stop/restart: drop `en` at cnt=1 of R=6. The period completes, then IDLE. Drop `en` and re-raise it within the period: no gap, continuous waveform.
- Edge ratios and independence:
  - Ratio 1 behaves as 2 (10 pattern).
  - Ratio 0 with `en`=1 stays IDLE.
  - Channel 0 at R=3 and channel 1 at R=8 run simultaneously with no interaction.
